// File: rtl/reaction_log_ctrl_pkg.sv
// Shared constants for the reaction-time log controller: widths, state
// encoding, the scan address table and the running-minimum seed.
package reaction_log_ctrl_pkg;

    localparam int GAME_DW    = 13;
    localparam int GAME_DEPTH = 5;
    localparam int SUM_W      = 16;
    localparam int ADDR_W     = 3;
    localparam int CNT_W      = 3;

    localparam logic [GAME_DW-1:0] MIN_SEED = {GAME_DW{1'b1}};

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_SCAN0 = 3'd2;
    localparam logic [2:0] ST_SCAN1 = 3'd3;
    localparam logic [2:0] ST_SCAN2 = 3'd4;
    localparam logic [2:0] ST_FIN   = 3'd5;

    typedef logic [ADDR_W-1:0] addr_t;

    // Each scan cycle reads two entries; SCAN2 reads only entry 4 on P.
    function automatic addr_t scan_rp(input logic [2:0] st);
        case (st)
            ST_SCAN0: scan_rp = 3'd0;
            ST_SCAN1: scan_rp = 3'd2;
            ST_SCAN2: scan_rp = 3'd4;
            default:  scan_rp = 3'd0;
        endcase
    endfunction

    function automatic addr_t scan_rq(input logic [2:0] st);
        case (st)
            ST_SCAN0: scan_rq = 3'd1;
            ST_SCAN1: scan_rq = 3'd3;
            default:  scan_rq = 3'd0;
        endcase
    endfunction

    function automatic logic scan_q_used(input logic [2:0] st);
        scan_q_used = (st == ST_SCAN0) || (st == ST_SCAN1);
    endfunction

endpackage

// File: rtl/reaction_log_ctrl_if.sv
// Bus bundle between the log controller (master) and its environment:
// request inputs, register-file ports and result outputs.
interface reaction_log_ctrl_if
    import reaction_log_ctrl_pkg::*;
#(
    parameter int DW = GAME_DW
);

    logic [DW-1:0]     NEW_TIME;
    logic              NEW_VALID;
    logic              CLR_LOG;
    logic [ADDR_W-1:0] WA;
    logic [DW-1:0]     LD_DATA;
    logic              WR;
    logic [ADDR_W-1:0] RP;
    logic [ADDR_W-1:0] RQ;
    logic [DW-1:0]     DATAP;
    logic [DW-1:0]     DATAQ;
    logic              BUSY;
    logic              DONE;
    logic [DW-1:0]     BEST;
    logic [SUM_W-1:0]  SUM;
    logic [CNT_W-1:0]  COUNT;

    modport master (
        input  NEW_TIME, NEW_VALID, CLR_LOG, DATAP, DATAQ,
        output WA, LD_DATA, WR, RP, RQ, BUSY, DONE, BEST, SUM, COUNT
    );

    modport slave (
        output NEW_TIME, NEW_VALID, CLR_LOG, DATAP, DATAQ,
        input  WA, LD_DATA, WR, RP, RQ, BUSY, DONE, BEST, SUM, COUNT
    );

endinterface

// File: rtl/log_accum.sv
// Combinational fold of one register-file read pair into the running
// minimum and sum; entries at or above the valid count are masked out.
module log_accum
    import reaction_log_ctrl_pkg::*;
#(
    parameter int DW = GAME_DW
) (
    input  logic [DW-1:0]     min_prev,
    input  logic [SUM_W-1:0]  sum_prev,
    input  logic [DW-1:0]     data_p,
    input  logic [DW-1:0]     data_q,
    input  logic [ADDR_W-1:0] idx_p,
    input  logic [ADDR_W-1:0] idx_q,
    input  logic              q_used,
    input  logic [CNT_W-1:0]  count,
    output logic [DW-1:0]     min_next,
    output logic [SUM_W-1:0]  sum_next
);

    logic p_ok;
    logic q_ok;
    logic [DW-1:0]    min_p;
    logic [SUM_W-1:0] sum_p;

    always_comb begin
        p_ok  = (idx_p < count);
        q_ok  = q_used && (idx_q < count);

        min_p = min_prev;
        sum_p = sum_prev;
        if (p_ok) begin
            if (data_p < min_p) min_p = data_p;
            sum_p = sum_p + SUM_W'(data_p);
        end

        min_next = min_p;
        sum_next = sum_p;
        if (q_ok) begin
            if (data_q < min_next) min_next = data_q;
            sum_next = sum_next + SUM_W'(data_q);
        end
    end

endmodule

// File: rtl/reaction_log_ctrl.sv
// Reaction-time log controller: writes each new time into a circular
// register file, then rescans all valid entries to publish BEST and SUM.
module reaction_log_ctrl
    import reaction_log_ctrl_pkg::*;
#(
    parameter int DW    = GAME_DW,
    parameter int DEPTH = GAME_DEPTH
) (
    input  logic               CLK,
    input  logic               CLRN,
    reaction_log_ctrl_if.master bus
);

    logic [2:0]        state;
    logic [ADDR_W-1:0] wptr;
    logic [CNT_W-1:0]  count;
    logic [DW-1:0]     best;
    logic [SUM_W-1:0]  sum_r;

    logic [DW-1:0]     lat_time;
    logic [DW-1:0]     run_min;
    logic [SUM_W-1:0]  run_sum;

    logic [DW-1:0]     min_prev;
    logic [SUM_W-1:0]  sum_prev;
    logic [DW-1:0]     min_next;
    logic [SUM_W-1:0]  sum_next;

    logic              in_write;
    logic              scanning;
    logic              take_new;

    assign in_write = (state == ST_WRITE);
    assign scanning = (state == ST_SCAN0) || (state == ST_SCAN1) || (state == ST_SCAN2);
    assign take_new = (state == ST_IDLE) && bus.NEW_VALID && !bus.CLR_LOG;

    // SCAN0 starts a fresh fold; later scan cycles continue the running values.
    assign min_prev = (state == ST_SCAN0) ? MIN_SEED : run_min;
    assign sum_prev = (state == ST_SCAN0) ? '0       : run_sum;

    log_accum #(.DW(DW)) u_accum (
        .min_prev (min_prev),
        .sum_prev (sum_prev),
        .data_p   (bus.DATAP),
        .data_q   (bus.DATAQ),
        .idx_p    (bus.RP),
        .idx_q    (bus.RQ),
        .q_used   (scan_q_used(state)),
        .count    (count),
        .min_next (min_next),
        .sum_next (sum_next)
    );

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= ST_IDLE;
            wptr  <= '0;
            count <= '0;
            best  <= MIN_SEED;
            sum_r <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.CLR_LOG) begin
                        wptr  <= '0;
                        count <= '0;
                        best  <= MIN_SEED;
                        sum_r <= '0;
                    end else if (bus.NEW_VALID) begin
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    wptr  <= (wptr == ADDR_W'(DEPTH - 1)) ? '0 : wptr + 1'b1;
                    count <= (count == CNT_W'(DEPTH)) ? count : count + 1'b1;
                    state <= ST_SCAN0;
                end
                ST_SCAN0: state <= ST_SCAN1;
                ST_SCAN1: state <= ST_SCAN2;
                ST_SCAN2: begin
                    best  <= min_next;
                    sum_r <= sum_next;
                    state <= ST_FIN;
                end
                ST_FIN:   state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Datapath holding registers; outputs derived from them are gated by state.
    always_ff @(posedge CLK) begin
        if (take_new) lat_time <= bus.NEW_TIME;
        if (scanning) begin
            run_min <= min_next;
            run_sum <= sum_next;
        end
    end

    assign bus.WR      = in_write;
    assign bus.WA      = in_write ? wptr : '0;
    assign bus.LD_DATA = in_write ? lat_time : '0;
    assign bus.RP      = scan_rp(state);
    assign bus.RQ      = scan_rq(state);
    assign bus.BUSY    = (state != ST_IDLE);
    assign bus.DONE    = (state == ST_FIN);
    assign bus.BEST    = best;
    assign bus.SUM     = sum_r;
    assign bus.COUNT   = count;

endmodule

// File: tb/tb_reaction_log_ctrl.sv
// Directed bench for reaction_log_ctrl with a behavioural 5-entry register
// file sharing the controller's reset.
module tb_reaction_log_ctrl;

    logic CLK;
    logic CLRN;

    reaction_log_ctrl_if #(.DW(13)) bus ();

    reaction_log_ctrl dut (
        .CLK  (CLK),
        .CLRN (CLRN),
        .bus  (bus)
    );

    logic [12:0] rf [5];

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            for (int i = 0; i < 5; i++) rf[i] <= '0;
        end else if (bus.WR) begin
            rf[bus.WA] <= bus.LD_DATA;
        end
    end

    assign bus.DATAP = (bus.RP < 3'd5) ? rf[bus.RP] : '0;
    assign bus.DATAQ = (bus.RQ < 3'd5) ? rf[bus.RQ] : '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int wr_cnt   = 0;
    int done_cnt = 0;

    always @(negedge CLK) begin
        if (bus.WR === 1'b1)   wr_cnt   = wr_cnt + 1;
        if (bus.DONE === 1'b1) done_cnt = done_cnt + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_log(input logic [12:0] v, input logic [2:0] exp_wa);
        int d0;
        d0 = done_cnt;
        bus.NEW_TIME  = v;
        bus.NEW_VALID = 1'b1;
        tick();
        bus.NEW_VALID = 1'b0;
        check("wr_in_write", bus.WR, 1);
        check("wa", bus.WA, exp_wa);
        check("ld_data", bus.LD_DATA, v);
        repeat (4) tick();
        check("done_hi", bus.DONE, 1);
        tick();
        check("done_lo", bus.DONE, 0);
        check("busy_lo", bus.BUSY, 0);
        check("done_pulses", done_cnt - d0, 1);
    endtask

    logic [12:0] s2_val  [5] = '{13'd500, 13'd200, 13'd800, 13'd350, 13'd410};
    logic [12:0] s2_best [5] = '{13'd500, 13'd200, 13'd200, 13'd200, 13'd200};
    logic [15:0] s2_sum  [5] = '{16'd500, 16'd700, 16'd1500, 16'd1850, 16'd2260};

    initial begin
        int w0;
        int d0;
        CLRN          = 1'b0;
        bus.NEW_TIME  = '0;
        bus.NEW_VALID = 1'b0;
        bus.CLR_LOG   = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_best", bus.BEST, 8191);
        check("rst_sum", bus.SUM, 0);
        check("rst_count", bus.COUNT, 0);
        check("rst_wr", bus.WR, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_rp", bus.RP, 0);
        check("rst_rq", bus.RQ, 0);
        check("rst_wa", bus.WA, 0);
        check("rst_ld", bus.LD_DATA, 0);
        CLRN = 1'b1;
        tick();

        // Scenario 1: single log
        do_log(13'd300, 3'd0);
        check("s1_best", bus.BEST, 300);
        check("s1_sum", bus.SUM, 300);
        check("s1_count", bus.COUNT, 1);

        // Scenario 2: empty the log, then five entries
        bus.CLR_LOG = 1'b1;
        tick();
        bus.CLR_LOG = 1'b0;
        check("s2_clr_count", bus.COUNT, 0);
        for (int i = 0; i < 5; i++) begin
            do_log(s2_val[i], 3'(i));
            check("s2_best", bus.BEST, s2_best[i]);
            check("s2_sum", bus.SUM, s2_sum[i]);
            check("s2_count", bus.COUNT, i + 1);
        end

        // Scenario 3: wrap to entry 0
        do_log(13'd100, 3'd0);
        check("s3_best", bus.BEST, 100);
        check("s3_sum", bus.SUM, 1860);
        check("s3_count", bus.COUNT, 5);

        // Scenario 4: NEW_VALID during SCAN1 is dropped; 50 lands at entry 1
        w0 = wr_cnt;
        d0 = done_cnt;
        bus.NEW_TIME  = 13'd50;
        bus.NEW_VALID = 1'b1;
        tick();
        bus.NEW_VALID = 1'b0;
        check("s4_wa", bus.WA, 1);
        tick();
        check("s4_scan0_rp", bus.RP, 0);
        check("s4_scan0_rq", bus.RQ, 1);
        tick();
        check("s4_scan1_rp", bus.RP, 2);
        check("s4_scan1_rq", bus.RQ, 3);
        bus.NEW_TIME  = 13'd7;
        bus.NEW_VALID = 1'b1;
        tick();
        bus.NEW_VALID = 1'b0;
        check("s4_scan2_rp", bus.RP, 4);
        repeat (5) tick();
        check("s4_writes", wr_cnt - w0, 1);
        check("s4_dones", done_cnt - d0, 1);
        check("s4_best", bus.BEST, 50);
        check("s4_sum", bus.SUM, 1710);
        check("s4_busy", bus.BUSY, 0);

        // Scenario 5: CLR_LOG beats NEW_VALID
        w0 = wr_cnt;
        bus.NEW_TIME  = 13'd123;
        bus.CLR_LOG   = 1'b1;
        bus.NEW_VALID = 1'b1;
        tick();
        bus.CLR_LOG   = 1'b0;
        bus.NEW_VALID = 1'b0;
        repeat (6) tick();
        check("s5_count", bus.COUNT, 0);
        check("s5_sum", bus.SUM, 0);
        check("s5_best", bus.BEST, 8191);
        check("s5_writes", wr_cnt - w0, 0);
        check("s5_busy", bus.BUSY, 0);

        // Scenario 6: reset during WRITE of a second entry
        do_log(13'd700, 3'd0);
        check("s6_pre_count", bus.COUNT, 1);
        w0 = wr_cnt;
        bus.NEW_TIME  = 13'd900;
        bus.NEW_VALID = 1'b1;
        tick();
        bus.NEW_VALID = 1'b0;
        check("s6_wa_before", bus.WA, 1);
        CLRN = 1'b0;
        #1;
        check("s6_wr", bus.WR, 0);
        check("s6_busy", bus.BUSY, 0);
        check("s6_wa", bus.WA, 0);
        check("s6_ld", bus.LD_DATA, 0);
        check("s6_count", bus.COUNT, 0);
        check("s6_best", bus.BEST, 8191);
        check("s6_sum", bus.SUM, 0);
        tick();
        CLRN = 1'b1;
        tick();
        check("s6_writes", wr_cnt - w0, 0);
        do_log(13'd600, 3'd0);
        check("s6_post_best", bus.BEST, 600);
        check("s6_post_sum", bus.SUM, 600);
        check("s6_post_count", bus.COUNT, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_log_ctrl.md
REACTION_LOG_CTRL -- requirements
Module: reaction_log_ctrl

Interface
REQ-001 SHALL have parameter DW, default 13, data width of one reaction-time entry.
REQ-002 SHALL have parameter DEPTH, default 5, number of log entries held in the attached register file (registers 0..DEPTH-1).
REQ-003 SHALL have port CLK  input  1  the single clock; all state SHALL change on the rising edge.
REQ-004 SHALL have port CLRN  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port NEW_TIME  input  DW  reaction time to log.
REQ-006 SHALL have port NEW_VALID  input  1  request to log NEW_TIME; sampled only in IDLE.
REQ-007 SHALL have port CLR_LOG  input  1  synchronous request to empty the log; sampled only in IDLE.
REQ-008 SHALL have port WA  output  3  register-file write address.
REQ-009 SHALL have port LD_DATA  output  DW  register-file write data.
REQ-010 SHALL have port WR  output  1  register-file write enable.
REQ-011 SHALL have port RP  output  3  register-file read address, port P.
REQ-012 SHALL have port RQ  output  3  register-file read address, port Q.
REQ-013 SHALL have port DATAP  input  DW  register-file read data P; combinational from RP.
REQ-014 SHALL have port DATAQ  input  DW  register-file read data Q; combinational from RQ.
REQ-015 SHALL have port BUSY  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse when BEST/SUM are updated.
REQ-017 SHALL have port BEST  output  DW  minimum of the valid log entries.
REQ-018 SHALL have port SUM  output  16  sum of the valid log entries.
REQ-019 SHALL have port COUNT  output  3  number of valid entries, 0..DEPTH.

Function
REQ-020 SHALL implement the states IDLE, WRITE, SCAN0, SCAN1, SCAN2 and FIN, entered in that order; FIN SHALL return to IDLE.
REQ-021 In IDLE with NEW_VALID=1, the block SHALL latch NEW_TIME and go to WRITE; otherwise it SHALL stay in IDLE.
REQ-022 In WRITE, the block SHALL drive WR=1, WA=wptr and LD_DATA=the latched value for exactly one cycle; at the end of that cycle wptr SHALL advance modulo DEPTH (4->0) and COUNT SHALL saturate at DEPTH.
REQ-023 WR SHALL be 0 in every state other than WRITE.
REQ-024 The read addresses SHALL be: SCAN0 RP=0, RQ=1; SCAN1 RP=2, RQ=3; SCAN2 RP=4, RQ=0 (Q ignored); in all other states RP=RQ=0.
REQ-025 Each scan cycle SHALL fold DATAP and DATAQ into a running minimum (initial 2^DW-1) and a running 16-bit sum (initial 0), using only entries whose index is below COUNT.
REQ-026 At the end of SCAN2, the block SHALL copy the running minimum and sum into BEST and SUM; in FIN, DONE SHALL be 1.
REQ-027 Latency SHALL be fixed: NEW_VALID sampled at edge 0, write at edge 1, BEST/SUM updated at edge 4, DONE high during cycle 4-5.
REQ-028 NEW_VALID and CLR_LOG SHALL be ignored while BUSY=1; no queuing.
REQ-029 In IDLE with CLR_LOG=1, the block SHALL set wptr=0, COUNT=0, BEST=2^DW-1 and SUM=0, with no write; when both are high, CLR_LOG SHALL win and NEW_VALID SHALL be dropped.
REQ-030 The SUM arithmetic SHALL be unsigned with no overflow (5 x 8191 < 2^16).

Reset
REQ-031 CLRN=0 SHALL force, asynchronously: state=IDLE, wptr=0, COUNT=0, BEST=2^DW-1, SUM=0, DONE=0, WR=0, WA=0, LD_DATA=0, RP=RQ=0.
REQ-032 When CLRN is asserted mid-operation (any state), the block SHALL abort with no partial write completing after the reset edge.
REQ-033 The attached register file shares CLRN, so its contents and COUNT=0 SHALL stay consistent after reset.

Structure
REQ-034 The state encoding, DW, DEPTH, the scan address table and the 2^DW-1 minimum seed SHALL live in a shared game package.
REQ-035 One sub-module, log_accum, SHALL hold the combinational min/sum fold of one read pair, including the index-valid masking.

Verification
REQ-036 Scenario 1: reset, then log 300 -> at edge 1 WR=1, WA=0, LD_DATA=300; at edge 4 BEST=300, SUM=300, COUNT=1; DONE is a one-cycle pulse.
REQ-037 Scenario 2: log 500, 200, 800, 350, 410 -> after the fifth: BEST=200, SUM=2260, COUNT=5.
REQ-038 Scenario 3: a sixth log of 100 -> written at WA=0 (wrap); BEST=100, SUM=1860, COUNT stays 5.
REQ-039 Scenario 4: pulse NEW_VALID during SCAN1 -> no extra WR and no second DONE.
REQ-040 Scenario 5: CLR_LOG and NEW_VALID in the same IDLE cycle -> COUNT=0, SUM=0, BEST=8191, WR stays 0.
REQ-041 Scenario 6: CLRN low during WRITE -> all outputs return to reset values; the next log goes to WA=0.
